// File: rtl/trigger_match_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trigger_match_ctrl_pkg
//  Shared definitions for the hardware trigger match controller:
//  mcontrol (type 2) field offsets, match and action encodings, FSM state
//  encodings, the request selection record and small decode helpers.
// -----------------------------------------------------------------------------
package trigger_match_ctrl_pkg;

   // mcontrol field positions within tdata1
   localparam int MC_TYPE_HI   = 31;
   localparam int MC_TYPE_LO   = 28;
   localparam int MC_DMODE_BIT = 27;
   localparam int MC_ACTION_HI = 15;
   localparam int MC_ACTION_LO = 12;
   localparam int MC_CHAIN_BIT = 11;
   localparam int MC_MATCH_HI  = 10;
   localparam int MC_MATCH_LO  = 7;
   localparam int MC_M_BIT     = 6;
   localparam int MC_EXEC_BIT  = 2;
   localparam int MC_STORE_BIT = 1;
   localparam int MC_LOAD_BIT  = 0;

   localparam logic [3:0] MC_TYPE_MCONTROL = 4'd2;

   // match field encodings (unsigned address compare)
   localparam logic [3:0] MATCH_EQ = 4'd0;
   localparam logic [3:0] MATCH_GE = 4'd2;
   localparam logic [3:0] MATCH_LT = 4'd3;

   // action field encodings
   localparam logic [3:0] ACTION_EXC = 4'd0;
   localparam logic [3:0] ACTION_DBG = 4'd1;

   // sequencer states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   // Winning trigger of a cycle: requested action and its index
   typedef struct packed {
      logic dbg;
      logic idx;
   } trig_sel_t;

   // Actions other than exception / debug entry make the trigger inert
   function automatic logic action_known(input logic [3:0] action);
      return (action == ACTION_EXC) || (action == ACTION_DBG);
   endfunction

   // Debug entry is only honoured when the trigger is debug-owned (dmode=1);
   // otherwise the request degrades to a breakpoint exception.
   function automatic logic action_is_dbg(input logic [3:0] action,
                                          input logic       dmode);
      return (action == ACTION_DBG) && dmode;
   endfunction

endpackage

// File: rtl/trigger_match_ctrl_trig_match_unit.sv
// -----------------------------------------------------------------------------
// trig_match_unit
//  Single mcontrol trigger evaluation: qualification (type, M-mode enable,
//  not in debug mode, known action) plus address compare against the fetch
//  PC and the load/store address.
//  Ports:
//   tdata1, tdata2        trigger configuration and compare value
//   priv_m, dbg_mode      hart privilege / debug state
//   if_valid, if_pc       fetch address stream
//   lsu_valid, lsu_wr,
//   lsu_addr              load/store address stream
//   fire                  trigger matched and qualified this cycle
//   act_dbg               resolved action (1 = debug entry, 0 = exception)
//   tval                  matched address (execute preferred over load/store)
// -----------------------------------------------------------------------------
module trig_match_unit
   import trigger_match_ctrl_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic [DW-1:0] tdata1,
   input  logic [DW-1:0] tdata2,
   input  logic          priv_m,
   input  logic          dbg_mode,
   input  logic          if_valid,
   input  logic [DW-1:0] if_pc,
   input  logic          lsu_valid,
   input  logic          lsu_wr,
   input  logic [DW-1:0] lsu_addr,
   output logic          fire,
   output logic          act_dbg,
   output logic [DW-1:0] tval
);

   logic [3:0] type_f;
   logic [3:0] action_f;
   logic [3:0] match_f;
   logic       qualified;
   logic       ls_dir_ok;
   logic       exec_hit;
   logic       ls_hit;
   logic       unused_fields;

   function automatic logic addr_hit(input logic [DW-1:0] addr,
                                     input logic [DW-1:0] cmp_v,
                                     input logic [3:0]    mode);
      logic hit;
      hit = 1'b0;
      case (mode)
         MATCH_EQ: hit = (addr == cmp_v);
         MATCH_GE: hit = (addr >= cmp_v);
         MATCH_LT: hit = (addr <  cmp_v);
         default:  hit = 1'b0;
      endcase
      return hit;
   endfunction

   assign type_f   = tdata1[MC_TYPE_HI:MC_TYPE_LO];
   assign action_f = tdata1[MC_ACTION_HI:MC_ACTION_LO];
   assign match_f  = tdata1[MC_MATCH_HI:MC_MATCH_LO];

   assign qualified = (type_f == MC_TYPE_MCONTROL)
                    && tdata1[MC_M_BIT] && priv_m
                    && !dbg_mode
                    && action_known(action_f);

   assign ls_dir_ok = lsu_wr ? tdata1[MC_STORE_BIT] : tdata1[MC_LOAD_BIT];

   assign exec_hit = qualified && tdata1[MC_EXEC_BIT] && if_valid
                   && addr_hit(if_pc, tdata2, match_f);
   assign ls_hit   = qualified && ls_dir_ok && lsu_valid
                   && addr_hit(lsu_addr, tdata2, match_f);

   assign fire    = exec_hit || ls_hit;
   assign act_dbg = action_is_dbg(action_f, tdata1[MC_DMODE_BIT]);
   assign tval    = exec_hit ? if_pc : lsu_addr;

   // chain is consumed by the controller; the rest is not modelled here
   assign unused_fields = ^{tdata1[26:16], tdata1[MC_CHAIN_BIT], tdata1[5:3]};

endmodule

// File: rtl/trigger_match_ctrl.sv
// -----------------------------------------------------------------------------
// trigger_match_ctrl
//  Evaluates two mcontrol hardware triggers every cycle and sequences the
//  resulting breakpoint-exception / debug-entry request to the core with a
//  req/ack handshake. Keeps sticky per-trigger hit flags.
//  Build option: define TRIG_CHAIN_EN to let tdata1_t0.chain pair triggers
//  0 and 1 (pair fires only when both match in the same cycle).
//  Ports:
//   cpu_clk, cpu_rstn       clock, async active-low reset
//   tdata1_t*, tdata2_t*    trigger configuration / compare values
//   priv_m, dbg_mode        hart state
//   if_valid, if_pc         fetch address stream
//   lsu_valid, lsu_wr,
//   lsu_addr                load/store address stream
//   trig_ack                core accepted the pending request
//   hit_clr                 per-trigger hit flag clear
//   trig_req, trig_action,
//   trig_idx, trig_tval     request and its payload (stable while req)
//   trig_hit                sticky per-trigger hit flags
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no request pending; first qualified fire latches payload
//  ST_REQ  | trig_req high, payload frozen until ack or dbg_mode cancel
// -----------------------------------------------------------------------------
module trigger_match_ctrl
   import trigger_match_ctrl_pkg::*;
#(
   parameter int DW    = 32,
   parameter int NTRIG = 2
) (
   input  logic             cpu_clk,
   input  logic             cpu_rstn,
   input  logic [DW-1:0]    tdata1_t0,
   input  logic [DW-1:0]    tdata1_t1,
   input  logic [DW-1:0]    tdata2_t0,
   input  logic [DW-1:0]    tdata2_t1,
   input  logic             priv_m,
   input  logic             dbg_mode,
   input  logic             if_valid,
   input  logic [DW-1:0]    if_pc,
   input  logic             lsu_valid,
   input  logic             lsu_wr,
   input  logic [DW-1:0]    lsu_addr,
   input  logic             trig_ack,
   input  logic [NTRIG-1:0] hit_clr,
   output logic             trig_req,
   output logic             trig_action,
   output logic             trig_idx,
   output logic [DW-1:0]    trig_tval,
   output logic [NTRIG-1:0] trig_hit
);

   logic             fire0;
   logic             fire1;
   logic             dbg0;
   logic             dbg1;
   logic [DW-1:0]    tval0;
   logic [DW-1:0]    tval1;

   logic             eff0;
   logic             eff1;
   logic [NTRIG-1:0] hit_set;
   logic             any_fire;
   trig_sel_t        sel_n;
   logic [DW-1:0]    tval_n;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   trig_sel_t        sel_q;
   trig_sel_t        sel_d;
   logic [DW-1:0]    tval_q;
   logic [DW-1:0]    tval_d;
   logic [NTRIG-1:0] hit_q;
   logic [NTRIG-1:0] hit_d;

   trig_match_unit #(.DW(DW)) u_match0 (
      .tdata1    (tdata1_t0),
      .tdata2    (tdata2_t0),
      .priv_m    (priv_m),
      .dbg_mode  (dbg_mode),
      .if_valid  (if_valid),
      .if_pc     (if_pc),
      .lsu_valid (lsu_valid),
      .lsu_wr    (lsu_wr),
      .lsu_addr  (lsu_addr),
      .fire      (fire0),
      .act_dbg   (dbg0),
      .tval      (tval0)
   );

   trig_match_unit #(.DW(DW)) u_match1 (
      .tdata1    (tdata1_t1),
      .tdata2    (tdata2_t1),
      .priv_m    (priv_m),
      .dbg_mode  (dbg_mode),
      .if_valid  (if_valid),
      .if_pc     (if_pc),
      .lsu_valid (lsu_valid),
      .lsu_wr    (lsu_wr),
      .lsu_addr  (lsu_addr),
      .fire      (fire1),
      .act_dbg   (dbg1),
      .tval      (tval1)
   );

`ifdef TRIG_CHAIN_EN
   logic chained;
   assign chained = tdata1_t0[MC_CHAIN_BIT];

   // A chained pair reports as trigger 1 (its action and tval); trigger 0
   // on its own never raises a request or a hit.
   always_comb begin
      eff0    = fire0 && !chained;
      eff1    = chained ? (fire0 && fire1) : fire1;
      hit_set = chained ? {2{fire0 && fire1}} : {fire1, fire0};
   end
`else
   always_comb begin
      eff0    = fire0;
      eff1    = fire1;
      hit_set = {fire1, fire0};
   end
`endif

   // Debug entry outranks exception; on equal actions trigger 0 wins.
   always_comb begin
      sel_n     = '0;
      sel_n.idx = eff1 && (!eff0 || (dbg1 && !dbg0));
      sel_n.dbg = sel_n.idx ? dbg1 : dbg0;
      tval_n    = sel_n.idx ? tval1 : tval0;
      any_fire  = eff0 || eff1;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tval_d  = tval_q;
      case (state_q)
         ST_IDLE: begin
            if (any_fire) begin
               state_d = ST_REQ;
               sel_d   = sel_n;
               tval_d  = tval_n;
            end
         end
         ST_REQ: begin
            // fires here are dropped; entering debug mode withdraws the
            // request without waiting for the core to ack it
            if (trig_ack || dbg_mode) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // set beats a same-cycle clear
   assign hit_d = (hit_q & ~hit_clr) | hit_set;

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         tval_q  <= '0;
         hit_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tval_q  <= tval_d;
         hit_q   <= hit_d;
      end
   end

   assign trig_req    = (state_q == ST_REQ);
   assign trig_action = sel_q.dbg;
   assign trig_idx    = sel_q.idx;
   assign trig_tval   = tval_q;
   assign trig_hit    = hit_q;

endmodule

// File: tb/tb_trigger_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trigger_match_ctrl
//  Directed scoreboard bench for trigger_match_ctrl. Stimulus pushes the
//  expected request payload; a negedge monitor pops it on each rising
//  trig_req and checks the payload every cycle the request is held.
// -----------------------------------------------------------------------------
module tb_trigger_match_ctrl;

   localparam int DW = 32;

   logic          cpu_clk = 1'b0;
   logic          cpu_rstn = 1'b0;
   logic [DW-1:0] tdata1_t0 = '0;
   logic [DW-1:0] tdata1_t1 = '0;
   logic [DW-1:0] tdata2_t0 = '0;
   logic [DW-1:0] tdata2_t1 = '0;
   logic          priv_m = 1'b0;
   logic          dbg_mode = 1'b0;
   logic          if_valid = 1'b0;
   logic [DW-1:0] if_pc = '0;
   logic          lsu_valid = 1'b0;
   logic          lsu_wr = 1'b0;
   logic [DW-1:0] lsu_addr = '0;
   logic          trig_ack = 1'b0;
   logic [1:0]    hit_clr = '0;
   logic          trig_req;
   logic          trig_action;
   logic          trig_idx;
   logic [DW-1:0] trig_tval;
   logic [1:0]    trig_hit;

   trigger_match_ctrl #(.DW(DW), .NTRIG(2)) dut (
      .cpu_clk     (cpu_clk),
      .cpu_rstn    (cpu_rstn),
      .tdata1_t0   (tdata1_t0),
      .tdata1_t1   (tdata1_t1),
      .tdata2_t0   (tdata2_t0),
      .tdata2_t1   (tdata2_t1),
      .priv_m      (priv_m),
      .dbg_mode    (dbg_mode),
      .if_valid    (if_valid),
      .if_pc       (if_pc),
      .lsu_valid   (lsu_valid),
      .lsu_wr      (lsu_wr),
      .lsu_addr    (lsu_addr),
      .trig_ack    (trig_ack),
      .hit_clr     (hit_clr),
      .trig_req    (trig_req),
      .trig_action (trig_action),
      .trig_idx    (trig_idx),
      .trig_tval   (trig_tval),
      .trig_hit    (trig_hit)
   );

   always #5 cpu_clk = ~cpu_clk;

   typedef struct packed {
      logic          action;
      logic          idx;
      logic [DW-1:0] tval;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] mk(input logic dmode, input logic [3:0] action,
                                      input logic chain, input logic [3:0] match,
                                      input logic m, input logic exe,
                                      input logic st, input logic ld);
      logic [31:0] v;
      v        = '0;
      v[31:28] = 4'd2;
      v[27]    = dmode;
      v[15:12] = action;
      v[11]    = chain;
      v[10:7]  = match;
      v[6]     = m;
      v[2]     = exe;
      v[1]     = st;
      v[0]     = ld;
      return v;
   endfunction

   task automatic step();
      @(negedge cpu_clk);
   endtask

   task automatic push(input logic action, input logic idx, input logic [DW-1:0] tval);
      exp_t e;
      e.action = action;
      e.idx    = idx;
      e.tval   = tval;
      exp_q.push_back(e);
   endtask

   task automatic ack_req();
      trig_ack = 1'b1;
      step();
      trig_ack = 1'b0;
      chk("req_low_after_ack", {63'd0, trig_req}, 64'd0);
   endtask

   // monitor
   logic req_prev = 1'b0;
   logic have_cur = 1'b0;
   exp_t cur;

   always @(negedge cpu_clk) begin
      if (!cpu_rstn) begin
         req_prev = 1'b0;
         have_cur = 1'b0;
      end else begin
         if (trig_req && !req_prev) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               have_cur = 1'b0;
               $display("FAIL unexpected_req actual=req idx=%0d tval=%0h required=no_req",
                        trig_idx, trig_tval);
            end else begin
               cur      = exp_q.pop_front();
               have_cur = 1'b1;
            end
         end
         if (trig_req && have_cur) begin
            chk("req_action", {63'd0, trig_action}, {63'd0, cur.action});
            chk("req_idx",    {63'd0, trig_idx},    {63'd0, cur.idx});
            chk("req_tval",   {32'd0, trig_tval},   {32'd0, cur.tval});
         end
         req_prev = trig_req;
      end
   end

   initial begin
      // reset state
      repeat (3) step();
      chk("rst_req",    {63'd0, trig_req},    64'd0);
      chk("rst_action", {63'd0, trig_action}, 64'd0);
      chk("rst_idx",    {63'd0, trig_idx},    64'd0);
      chk("rst_tval",   {32'd0, trig_tval},   64'd0);
      chk("rst_hit",    {62'd0, trig_hit},    64'd0);
      cpu_rstn = 1'b1;
      priv_m   = 1'b1;
      step();

      // t0 execute equal 0x100, exception
      tdata1_t0 = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tdata2_t0 = 32'h100;
      if_valid  = 1'b1;
      if_pc     = 32'h100;
      push(1'b0, 1'b0, 32'h100);
      step();
      if_valid = 1'b0;
      chk("exec_req", {63'd0, trig_req}, 64'd1);
      chk("exec_hit", {62'd0, trig_hit}, 64'd1);
      ack_req();
      if_valid = 1'b1;
      if_pc    = 32'h104;
      step();
      if_valid = 1'b0;
      step();
      chk("exec_nomatch", {63'd0, trig_req}, 64'd0);
      hit_clr = 2'b01;
      step();
      hit_clr = 2'b00;
      chk("hit_clr0", {62'd0, trig_hit}, 64'd0);

      // t1 store >= 0x8000_0000, debug entry
      tdata1_t0 = '0;
      tdata1_t1 = mk(1'b1, 4'd1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tdata2_t1 = 32'h8000_0000;
      lsu_valid = 1'b1;
      lsu_wr    = 1'b1;
      lsu_addr  = 32'h7FFF_FFFC;
      step();
      lsu_valid = 1'b0;
      step();
      chk("ge_below", {63'd0, trig_req}, 64'd0);
      lsu_valid = 1'b1;
      lsu_wr    = 1'b0;
      lsu_addr  = 32'h8000_0010;
      step();
      lsu_valid = 1'b0;
      step();
      chk("load_on_store_trig", {63'd0, trig_req}, 64'd0);
      lsu_valid = 1'b1;
      lsu_wr    = 1'b1;
      push(1'b1, 1'b1, 32'h8000_0010);
      step();
      lsu_valid = 1'b0;
      chk("store_req", {63'd0, trig_req}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("store_hold", {63'd0, trig_req}, 64'd1);
      end
      ack_req();
      chk("store_hit", {62'd0, trig_hit}, 64'd2);
      lsu_valid = 1'b1;
      lsu_addr  = 32'h8000_0000;
      push(1'b1, 1'b1, 32'h8000_0000);
      step();
      lsu_valid = 1'b0;
      chk("ge_equal_req", {63'd0, trig_req}, 64'd1);
      ack_req();
      hit_clr = 2'b11;
      step();
      hit_clr = 2'b00;

      // both fire: debug beats exception; fire during REQ dropped
      tdata1_t0 = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      if_valid  = 1'b1;
      if_pc     = 32'h100;
      lsu_valid = 1'b1;
      lsu_addr  = 32'h8000_0010;
      push(1'b1, 1'b1, 32'h8000_0010);
      step();
      lsu_valid = 1'b0;
      chk("both_req", {63'd0, trig_req}, 64'd1);
      chk("both_hit", {62'd0, trig_hit}, 64'd3);
      step();
      if_valid = 1'b0;
      ack_req();
      step();
      chk("dropped_no_req", {63'd0, trig_req}, 64'd0);
      hit_clr = 2'b11;
      step();
      hit_clr = 2'b00;
      chk("hit_clr_all", {62'd0, trig_hit}, 64'd0);

      // equal actions -> trigger 0 wins
      tdata1_t1 = mk(1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      if_valid  = 1'b1;
      lsu_valid = 1'b1;
      push(1'b0, 1'b0, 32'h100);
      step();
      if_valid  = 1'b0;
      lsu_valid = 1'b0;
      chk("tie_req", {63'd0, trig_req}, 64'd1);
      ack_req();

      // debug action without dmode degrades to exception
      tdata1_t1 = '0;
      tdata1_t0 = mk(1'b0, 4'd1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      if_valid  = 1'b1;
      push(1'b0, 1'b0, 32'h100);
      step();
      if_valid = 1'b0;
      ack_req();
      hit_clr = 2'b11;
      step();
      hit_clr = 2'b00;

      // dbg_mode / priv gating and cancel
      tdata1_t0 = mk(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      dbg_mode  = 1'b1;
      if_valid  = 1'b1;
      step();
      step();
      if_valid = 1'b0;
      chk("dbg_no_req", {63'd0, trig_req}, 64'd0);
      chk("dbg_no_hit", {62'd0, trig_hit}, 64'd0);
      dbg_mode = 1'b0;
      priv_m   = 1'b0;
      if_valid = 1'b1;
      step();
      if_valid = 1'b0;
      step();
      chk("umode_no_req", {63'd0, trig_req}, 64'd0);
      priv_m   = 1'b1;
      if_valid = 1'b1;
      push(1'b0, 1'b0, 32'h100);
      step();
      if_valid = 1'b0;
      chk("pre_cancel_req", {63'd0, trig_req}, 64'd1);
      dbg_mode = 1'b1;
      step();
      dbg_mode = 1'b0;
      chk("dbg_cancel", {63'd0, trig_req}, 64'd0);

      // hit_clr with simultaneous fire: set wins
      hit_clr  = 2'b01;
      if_valid = 1'b1;
      push(1'b0, 1'b0, 32'h100);
      step();
      hit_clr  = 2'b00;
      if_valid = 1'b0;
      chk("clr_set_wins", {62'd0, trig_hit}, 64'd1);
      ack_req();
      hit_clr = 2'b01;
      step();
      hit_clr = 2'b00;
      chk("clr_alone", {62'd0, trig_hit}, 64'd0);

      // t1 load < 0x300
      tdata1_t0 = '0;
      tdata1_t1 = mk(1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      tdata2_t1 = 32'h300;
      lsu_valid = 1'b1;
      lsu_wr    = 1'b0;
      lsu_addr  = 32'h300;
      step();
      lsu_valid = 1'b0;
      step();
      chk("lt_equal_no_req", {63'd0, trig_req}, 64'd0);
      lsu_valid = 1'b1;
      lsu_addr  = 32'h2FC;
      push(1'b0, 1'b1, 32'h2FC);
      step();
      lsu_valid = 1'b0;
      chk("lt_req", {63'd0, trig_req}, 64'd1);
      ack_req();
      chk("lt_hit", {62'd0, trig_hit}, 64'd2);
      hit_clr = 2'b11;
      step();
      hit_clr = 2'b00;

`ifdef TRIG_CHAIN_EN
      tdata1_t0 = mk(1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tdata2_t0 = 32'h200;
      tdata1_t1 = mk(1'b1, 4'd1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      if_valid  = 1'b1;
      if_pc     = 32'h200;
      step();
      if_valid = 1'b0;
      step();
      chk("chain_pc_only", {63'd0, trig_req}, 64'd0);
      chk("chain_pc_only_hit", {62'd0, trig_hit}, 64'd0);
      if_valid  = 1'b1;
      lsu_valid = 1'b1;
      lsu_wr    = 1'b0;
      lsu_addr  = 32'h2FC;
      push(1'b1, 1'b1, 32'h2FC);
      step();
      if_valid  = 1'b0;
      lsu_valid = 1'b0;
      chk("chain_req", {63'd0, trig_req}, 64'd1);
      chk("chain_hit", {62'd0, trig_hit}, 64'd3);
      ack_req();
      hit_clr = 2'b11;
      step();
      hit_clr = 2'b00;
`endif

      // reset during REQ aborts request and clears everything
      tdata1_t0 = '0;
      tdata1_t1 = mk(1'b1, 4'd1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0);
      tdata2_t1 = 32'h8000_0000;
      lsu_valid = 1'b1;
      lsu_wr    = 1'b1;
      lsu_addr  = 32'h8000_0010;
      push(1'b1, 1'b1, 32'h8000_0010);
      step();
      lsu_valid = 1'b0;
      chk("pre_rst_req", {63'd0, trig_req}, 64'd1);
      #2;
      cpu_rstn = 1'b0;
      #1;
      chk("mid_rst_req",    {63'd0, trig_req},    64'd0);
      chk("mid_rst_action", {63'd0, trig_action}, 64'd0);
      chk("mid_rst_idx",    {63'd0, trig_idx},    64'd0);
      chk("mid_rst_tval",   {32'd0, trig_tval},   64'd0);
      chk("mid_rst_hit",    {62'd0, trig_hit},    64'd0);
      step();
      cpu_rstn = 1'b1;
      step();
      step();
      chk("post_rst_req", {63'd0, trig_req}, 64'd0);

      chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
